instr_fetch_unit: RTL

Multicycle instruction-fetch stage sitting directly upstream of the main control FSM. It owns the PC register, drives the instruction-memory read with a fixed, parameterised latency, captures the returned word into the instruction register, and presents `Op` to the control unit. It also applies the control unit's PC-write requests (branch, jump, ALU result) between fetches.

---
 rtl/instr_fetch_unit_if.sv | 18 +
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and the memory (slave).
interface instr_fetch_unit_if;
  logic [31:0] MemAddr;
  logic        MemRead;
  logic [31:0] MemRdata;

  modport master (
    output MemAddr,
    output MemRead,
    input  MemRdata
  );

  modport slave (
    input  MemAddr,
    input  MemRead,
    output MemRdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch: owns the PC, performs a fixed-latency memory read,
// latches the instruction and applies control-unit PC writes while idle.
module instr_fetch_unit #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       Start,
  input  logic                       PCWrite,
  input  logic                       PCWriteCond,
  input  logic                       Zero,
  input  logic [1:0]                 PCSource,
  input  logic [31:0]                ALUResult,
  input  logic [31:0]                ALUOut,
  instr_fetch_unit_if.master         imem,
  output logic [31:0]                Instr,
  output logic [5:0]                 Op,
  output logic [31:0]                PC,
  output logic                       Busy,
  output logic                       Done,
  output logic [1:0]                 StateOut
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_RST = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                mem_read_q, mem_read_d;
  logic [ADDR_W-1:0]   pc_src;
  logic                pc_load;

  // PC load source; PCSource 3 is reserved and never loads
  always_comb begin
    pc_src  = ALUResult;
    pc_load = (PCWrite || (PCWriteCond && Zero)) && (PCSource != 2'd3);
    case (PCSource)
      2'd0:    pc_src = ALUResult;
      2'd1:    pc_src = ALUOut;
      2'd2:    pc_src = {pc_q[31:28], instr_q[25:0], 2'b00};
      default: pc_src = pc_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pc_q       <= PC_RST;
      instr_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mem_read_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      mem_read_q <= mem_read_d;
    end
  end

  // Next-state and datapath updates; PC only changes in IDLE or on capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pc_load) begin
          pc_d = {pc_src[31:2], 2'b00};
        end
        if (Start) begin
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d   = CNT_W'(MEM_LATENCY - 1);
        state_d = (MEM_LATENCY == 1) ? CAPTURE : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        instr_d = imem.MemRdata;
        pc_d    = pc_q + ADDR_W'(4);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    mem_read_d = (state_d != IDLE);
  end

  assign imem.MemAddr = pc_q;
  assign imem.MemRead = mem_read_q;
  assign Instr        = instr_q;
  assign Op           = instr_q[31:26];
  assign PC           = pc_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign StateOut     = state_q;

endmodule
